// File: rtl/filter_scan_sequencer.sv
// filter_scan_sequencer
// Steps the test-signal generator through a programmed delay sweep. For each
// step it waits for the filters to settle, records the signed peak of one
// selected filter output over a dwell window, and then offers the result on a
// valid/ready handshake.
// Optional build macro: FILTER_SCAN_SEQ_TIMEOUT_EN. When it is defined, a
// result that waits TIMEOUT_CYCLES in REPORT is discarded and result_dropped
// latches high.
module filter_scan_sequencer #(
  parameter int SIZE_DELAY       = 8,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int SETTLE_CYCLES    = 16,
  parameter int DWELL_CYCLES     = 256,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [SIZE_DELAY-1:0]         cfg_delay_first,
  input  logic [SIZE_DELAY-1:0]         cfg_delay_last,
  input  logic [SIZE_DELAY-1:0]         cfg_delay_step,
  input  logic [1:0]                    cfg_overlay_mode,
  input  logic                          cfg_rate,
  input  logic [2:0]                    cfg_filter_sel,
  input  logic [6*SIZE_FILTER_DATA-1:0] filter_data,
  output logic                          test_overlay,
  output logic                          test_rate,
  output logic [SIZE_DELAY-1:0]         test_delay,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [SIZE_DELAY-1:0]         result_delay,
  output logic                          result_overlay,
  output logic [SIZE_FILTER_DATA-1:0]   result_peak,
  output logic [((DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1)-1:0] result_peak_pos,
  output logic                          busy,
  output logic                          done,
  output logic                          result_dropped
);

  localparam int POS_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int W     = SIZE_FILTER_DATA;
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] DWELL_LAST  = 32'(DWELL_CYCLES - 1);

  // Every phase must last at least one cycle for the counters to terminate.
  if (SETTLE_CYCLES < 1 || DWELL_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("filter_scan_sequencer: cycle-count parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SETTLE, S_MEASURE, S_REPORT, S_NEXT, S_DONE
  } state_t;

  state_t                  state;
  logic [SIZE_DELAY-1:0]   last_q;
  logic [SIZE_DELAY-1:0]   step_q;
  logic [1:0]              mode_q;
  logic                    rate_q;
  logic [2:0]              sel_q;
  logic [SIZE_DELAY-1:0]   cur_delay;
  logic                    cur_overlay;
  logic [31:0]             cnt;
  logic [SIZE_DELAY:0]     next_sum;
  logic [W-1:0]            sample;

  // The current step is what gets reported; both stay put while in REPORT.
  assign result_delay   = cur_delay;
  assign result_overlay = cur_overlay;

  // One extra bit so a sweep near the top of the range cannot wrap around.
  assign next_sum = {1'b0, cur_delay} + {1'b0, step_q};

  // Channel select; codes 6 and 7 fall back to v1.
  always_comb begin
    case (sel_q)
      3'd1:    sample = filter_data[1*W +: W];
      3'd2:    sample = filter_data[2*W +: W];
      3'd3:    sample = filter_data[3*W +: W];
      3'd4:    sample = filter_data[4*W +: W];
      3'd5:    sample = filter_data[5*W +: W];
      default: sample = filter_data[0 +: W];
    endcase
  end

`ifndef FILTER_SCAN_SEQ_TIMEOUT_EN
  assign result_dropped = 1'b0;
`endif

  // Sweep sequencer: configuration latch, generator controls, peak search and handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      last_q          <= '0;
      step_q          <= '0;
      mode_q          <= '0;
      rate_q          <= 1'b0;
      sel_q           <= '0;
      cur_delay       <= '0;
      cur_overlay     <= 1'b0;
      cnt             <= '0;
      test_overlay    <= 1'b0;
      test_rate       <= 1'b0;
      test_delay      <= '0;
      result_valid    <= 1'b0;
      result_peak     <= '0;
      result_peak_pos <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef FILTER_SCAN_SEQ_TIMEOUT_EN
      result_dropped  <= 1'b0;
`endif
    end else if (abort && state != S_IDLE) begin
      state        <= S_IDLE;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            last_q      <= cfg_delay_last;
            step_q      <= cfg_delay_step;
            mode_q      <= cfg_overlay_mode;
            rate_q      <= cfg_rate;
            sel_q       <= cfg_filter_sel;
            cur_delay   <= cfg_delay_first;
            cur_overlay <= (cfg_overlay_mode == 2'd1);
            busy        <= 1'b1;
            state       <= S_SETUP;
`ifdef FILTER_SCAN_SEQ_TIMEOUT_EN
            result_dropped <= 1'b0;
`endif
          end
        end
        S_SETUP: begin
          test_delay   <= cur_delay;
          test_overlay <= cur_overlay;
          test_rate    <= rate_q;
          cnt          <= '0;
          state        <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt             <= '0;
            result_peak     <= {1'b1, {(W-1){1'b0}}};
            result_peak_pos <= '0;
            state           <= S_MEASURE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_MEASURE: begin
          if ($signed(sample) > $signed(result_peak)) begin
            result_peak     <= sample;
            result_peak_pos <= cnt[POS_W-1:0];
          end
          if (cnt == DWELL_LAST) begin
            cnt          <= '0;
            result_valid <= 1'b1;
            state        <= S_REPORT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_REPORT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= S_NEXT;
          end
`ifdef FILTER_SCAN_SEQ_TIMEOUT_EN
          else if (cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            result_valid   <= 1'b0;
            result_dropped <= 1'b1;
            state          <= S_NEXT;
          end else begin
            cnt <= cnt + 32'd1;
          end
`endif
        end
        S_NEXT: begin
          if (mode_q == 2'd2 && !cur_overlay) begin
            cur_overlay <= 1'b1;
            state       <= S_SETUP;
          end else if (step_q == '0 || next_sum > {1'b0, last_q}) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            cur_delay   <= next_sum[SIZE_DELAY-1:0];
            cur_overlay <= (mode_q == 2'd1);
            state       <= S_SETUP;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_scan_sequencer.sv
// Bench for filter_scan_sequencer: random filter data and sweep settings,
// checked against a step list, schedule and window-peak model built here.
module tb_filter_scan_sequencer;

  localparam int S      = 16;
  localparam int D      = 256;
  localparam int FW     = 16;
  localparam int DL     = 8;
  localparam int TO     = 8;
  localparam int STEP_T = S + D + 3;

  logic          clk = 1'b0;
  logic          reset, start, abort, result_ready;
  logic [DL-1:0] cfg_delay_first, cfg_delay_last, cfg_delay_step;
  logic [1:0]    cfg_overlay_mode;
  logic          cfg_rate;
  logic [2:0]    cfg_filter_sel;
  logic [6*FW-1:0] filter_data;
  logic          test_overlay, test_rate;
  logic [DL-1:0] test_delay;
  logic          result_valid;
  logic [DL-1:0] result_delay;
  logic          result_overlay;
  logic [FW-1:0] result_peak;
  logic [7:0]    result_peak_pos;
  logic          busy, done, result_dropped;

  filter_scan_sequencer #(
    .SIZE_DELAY(DL), .SIZE_FILTER_DATA(FW), .SETTLE_CYCLES(S),
    .DWELL_CYCLES(D), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_delay_first(cfg_delay_first), .cfg_delay_last(cfg_delay_last),
    .cfg_delay_step(cfg_delay_step), .cfg_overlay_mode(cfg_overlay_mode),
    .cfg_rate(cfg_rate), .cfg_filter_sel(cfg_filter_sel), .filter_data(filter_data),
    .test_overlay(test_overlay), .test_rate(test_rate), .test_delay(test_delay),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_delay(result_delay), .result_overlay(result_overlay),
    .result_peak(result_peak), .result_peak_pos(result_peak_pos),
    .busy(busy), .done(done), .result_dropped(result_dropped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Edge counter and per-edge record of the filter inputs.
  int cyc = 0;
  logic [95:0] hist [0:65535];
  always @(posedge clk) begin
    if (cyc < 65536) hist[cyc] <= filter_data;
    cyc <= cyc + 1;
  end

  int c0 = -100000;
  int pat_on = 0;

  function automatic logic [15:0] rand_word();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 15)) - 16'd8;
  endfunction

  function automatic logic [15:0] chan(input logic [95:0] w, input int sel);
    int s;
    s = (sel > 5) ? 0 : sel;
    return w[s*16 +: 16];
  endfunction

  // Filter data driver: tie-heavy random words, or the peak-tie pattern on v2.
  always @(negedge clk) begin
    logic [95:0] w;
    int k;
    for (int i = 0; i < 6; i++) w[i*16 +: 16] = rand_word();
    if (pat_on != 0) begin
      k = cyc - (c0 + S + 2);
      w[31:16] = 16'h0100;
      if (k == 5 || k == 9) w[31:16] = 16'h7FFF;
      if (k == 200) w[31:16] = 16'h8000;
    end
    filter_data = w;
  end

  // Signed maximum of the selected channel over a window, first index on ties.
  task automatic model_window(input int w0, input int sel, output logic [15:0] pk, output int pos);
    pk = chan(hist[w0], sel);
    pos = 0;
    for (int k = 1; k < D; k++)
      if ($signed(chan(hist[w0 + k], sel)) > $signed(pk)) begin
        pk = chan(hist[w0 + k], sel);
        pos = k;
      end
  endtask

  int exp_d[$], exp_o[$];
  task automatic build_exp(input int first, input int last, input int step, input int mode);
    int d;
    exp_d.delete(); exp_o.delete();
    d = first;
    forever begin
      if (mode == 2) begin
        exp_d.push_back(d); exp_o.push_back(0);
        exp_d.push_back(d); exp_o.push_back(1);
      end else begin
        exp_d.push_back(d); exp_o.push_back(mode == 1 ? 1 : 0);
      end
      if (step == 0 || d + step > last) break;
      d += step;
    end
  endtask

  int lsel, lrate;
  task automatic launch(input int first, input int last, input int step,
                        input int mode, input int sel, input int rate);
    @(negedge clk);
    cfg_delay_first  = DL'(first);
    cfg_delay_last   = DL'(last);
    cfg_delay_step   = DL'(step);
    cfg_overlay_mode = 2'(mode);
    cfg_filter_sel   = 3'(sel);
    cfg_rate         = 1'(rate);
    lsel = sel; lrate = rate;
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    cfg_delay_first  = DL'($urandom);
    cfg_delay_last   = DL'($urandom);
    cfg_delay_step   = DL'($urandom);
    cfg_overlay_mode = 2'($urandom);
    cfg_filter_sel   = 3'($urandom);
    cfg_rate         = 1'($urandom);
  endtask

  // Observation of one sweep (no comparisons here).
  int q_d[$], q_o[$], q_pk[$], q_pos[$], q_rise[$], q_tovl[$], q_tdel[$], q_trate[$], q_vlen[$];
  int n_done, busy_after, coll_to, ovl_chg;
  task automatic collect(input int budget);
    int prev_v, vlen, fin;
    logic pt;
    q_d.delete(); q_o.delete(); q_pk.delete(); q_pos.delete(); q_rise.delete();
    q_tovl.delete(); q_tdel.delete(); q_trate.delete(); q_vlen.delete();
    n_done = 0; busy_after = 1; ovl_chg = 0; fin = 0; prev_v = 0; vlen = 0;
    pt = test_overlay;
    for (int i = 0; i < budget && fin == 0; i++) begin
      @(negedge clk);
      if (test_overlay !== pt) ovl_chg++;
      pt = test_overlay;
      if (result_valid) begin
        if (prev_v == 0) begin
          q_d.push_back(int'(result_delay)); q_o.push_back(int'(result_overlay));
          q_pk.push_back(int'(result_peak)); q_pos.push_back(int'(result_peak_pos));
          q_rise.push_back(cyc - 1); q_tovl.push_back(int'(test_overlay));
          q_tdel.push_back(int'(test_delay)); q_trate.push_back(int'(test_rate));
          vlen = 0;
        end
        vlen++;
      end else if (prev_v != 0) q_vlen.push_back(vlen);
      prev_v = result_valid ? 1 : 0;
      if (done) begin
        n_done++;
        @(negedge clk);
        busy_after = busy ? 1 : 0;
        fin = 1;
      end
    end
    coll_to = (fin == 0) ? 1 : 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({test_overlay, test_rate, test_delay, result_valid, result_delay, result_overlay,
         result_peak, result_peak_pos, busy, done, result_dropped} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got nonzero outputs busy=%b valid=%b delay=%0h expected all 0",
               busy, result_valid, test_delay);
    end
    reset = 1'b0;
  endtask

  task automatic test_sweep();
    logic [15:0] mpk; int mpos;
    result_ready = 1'b1;
    launch(10, 30, 10, 0, 1, 1);
    collect(2000);
    checks++; if (coll_to != 0) begin failures++; $display("FAIL sweep_timeout: got no done expected done"); end
    checks++; if (q_d.size() != 3) begin failures++; $display("FAIL sweep_count: got %0d expected 3", q_d.size()); end
    for (int j = 0; j < q_d.size() && j < 3; j++) begin
      model_window(c0 + S + 2 + j*STEP_T, 1, mpk, mpos);
      checks++; if (q_d[j] != 10*(j+1)) begin failures++; $display("FAIL sweep_delay[%0d]: got %0d expected %0d", j, q_d[j], 10*(j+1)); end
      checks++; if (q_o[j] != 0) begin failures++; $display("FAIL sweep_overlay[%0d]: got %0d expected 0", j, q_o[j]); end
      checks++; if (q_pk[j] != int'(mpk) || q_pos[j] != mpos) begin failures++; $display("FAIL sweep_peak[%0d]: got %0h@%0d expected %0h@%0d", j, q_pk[j], q_pos[j], mpk, mpos); end
      checks++; if (q_tdel[j] != 10*(j+1) || q_trate[j] != 1) begin failures++; $display("FAIL sweep_test_out[%0d]: got delay %0d rate %0d expected %0d 1", j, q_tdel[j], q_trate[j], 10*(j+1)); end
    end
    checks++; if (q_rise.size() == 0 || q_rise[0] - c0 != 273) begin failures++; $display("FAIL first_latency: got %0d expected 273", q_rise.size() ? q_rise[0] - c0 : -1); end
    checks++; if (n_done != 1 || busy_after != 0) begin failures++; $display("FAIL sweep_done: got done=%0d busy_after=%0d expected 1 0", n_done, busy_after); end
    checks++; if (result_dropped !== 1'b0) begin failures++; $display("FAIL sweep_dropped: got %b expected 0", result_dropped); end
  endtask

  task automatic test_peak_tie();
    result_ready = 1'b1;
    pat_on = 1;
    launch(5, 5, 1, 0, 1, 0);
    collect(1000);
    pat_on = 0;
    checks++; if (q_pk.size() != 1) begin failures++; $display("FAIL tie_count: got %0d expected 1", q_pk.size()); end
    else begin
      checks++; if (q_pk[0] != 32'h7FFF) begin failures++; $display("FAIL tie_peak: got %0h expected 7fff", q_pk[0]); end
      checks++; if (q_pos[0] != 5) begin failures++; $display("FAIL tie_pos: got %0d expected 5", q_pos[0]); end
    end
  endtask

  task automatic test_overlay_both();
    logic [15:0] mpk; int mpos, s;
    result_ready = 1'b1;
    s = $urandom_range(0, 7);
    launch(4, 4, 3, 2, s, 0);
    collect(2000);
    checks++; if (q_d.size() != 2) begin failures++; $display("FAIL both_count: got %0d expected 2", q_d.size()); end
    for (int j = 0; j < q_d.size() && j < 2; j++) begin
      model_window(c0 + S + 2 + j*STEP_T, s, mpk, mpos);
      checks++; if (q_d[j] != 4 || q_o[j] != j || q_tovl[j] != j) begin failures++; $display("FAIL both_step[%0d]: got delay %0d ovl %0d test_ovl %0d expected 4 %0d %0d", j, q_d[j], q_o[j], q_tovl[j], j, j); end
      checks++; if (q_pk[j] != int'(mpk) || q_pos[j] != mpos) begin failures++; $display("FAIL both_peak[%0d]: got %0h@%0d expected %0h@%0d", j, q_pk[j], q_pos[j], mpk, mpos); end
    end
    checks++; if (ovl_chg != 1) begin failures++; $display("FAIL both_toggles: got %0d expected 1", ovl_chg); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL both_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_overflow();
    result_ready = 1'b1;
    launch(250, 255, 10, 0, 0, 0);
    collect(1000);
    checks++; if (q_d.size() != 1 || q_d[0] != 250 || n_done != 1) begin failures++; $display("FAIL overflow_guard: got %0d results first %0d done %0d expected 1 250 1", q_d.size(), q_d.size() ? q_d[0] : -1, n_done); end
    launch(20, 200, 0, 0, 3, 0);
    collect(1000);
    checks++; if (q_d.size() != 1 || q_d[0] != 20 || n_done != 1) begin failures++; $display("FAIL zero_step: got %0d results first %0d done %0d expected 1 20 1", q_d.size(), q_d.size() ? q_d[0] : -1, n_done); end
  endtask

  task automatic test_random_sweeps();
    int f, l, st, m, s, r;
    logic [15:0] mpk; int mpos;
    result_ready = 1'b1;
    for (int it = 0; it < 4; it++) begin
      f  = $urandom_range(0, 255);
      l  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : f + $urandom_range(0, 60);
      if (l > 255) l = 255;
      st = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(15, 40);
      m  = $urandom_range(0, 3);
      s  = $urandom_range(0, 7);
      r  = $urandom_range(0, 1);
      build_exp(f, l, st, m);
      launch(f, l, st, m, s, r);
      collect(STEP_T * 12);
      checks++; if (q_d.size() != exp_d.size()) begin failures++; $display("FAIL rand%0d_count: got %0d expected %0d", it, q_d.size(), exp_d.size()); end
      for (int j = 0; j < q_d.size() && j < exp_d.size(); j++) begin
        model_window(c0 + S + 2 + j*STEP_T, s, mpk, mpos);
        checks++; if (q_d[j] != exp_d[j] || q_o[j] != exp_o[j]) begin failures++; $display("FAIL rand%0d_step[%0d]: got %0d/%0d expected %0d/%0d", it, j, q_d[j], q_o[j], exp_d[j], exp_o[j]); end
        checks++; if (q_pk[j] != int'(mpk) || q_pos[j] != mpos) begin failures++; $display("FAIL rand%0d_peak[%0d]: got %0h@%0d expected %0h@%0d", it, j, q_pk[j], q_pos[j], mpk, mpos); end
        checks++; if (q_rise[j] != c0 + 1 + S + D + j*STEP_T) begin failures++; $display("FAIL rand%0d_timing[%0d]: got %0d expected %0d", it, j, q_rise[j] - c0, 1 + S + D + j*STEP_T); end
        checks++; if (q_tdel[j] != exp_d[j] || q_tovl[j] != exp_o[j] || q_trate[j] != r) begin failures++; $display("FAIL rand%0d_test_out[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", it, j, q_tdel[j], q_tovl[j], q_trate[j], exp_d[j], exp_o[j], r); end
      end
      checks++; if (n_done != 1 || busy_after != 0) begin failures++; $display("FAIL rand%0d_done: got %0d busy %0d expected 1 0", it, n_done, busy_after); end
    end
  endtask

`ifndef FILTER_SCAN_SEQ_TIMEOUT_EN
  task automatic test_backpressure_abort();
    int got, s, cd, co, cpk, cpos, mpos;
    logic [15:0] mpk;
    result_ready = 1'b0;
    s = $urandom_range(0, 7);
    launch(7, 9, 1, 0, s, 1);
    got = 0;
    for (int i = 0; i < 400 && got == 0; i++) begin
      @(negedge clk);
      if (result_valid) got = 1;
    end
    checks++; if (got == 0) begin failures++; $display("FAIL bp_valid: got no result_valid expected one"); end
    if (got != 0) begin
      checks++; if (cyc - 1 - c0 != 273) begin failures++; $display("FAIL bp_latency: got %0d expected 273", cyc - 1 - c0); end
      model_window(c0 + S + 2, s, mpk, mpos);
      checks++; if (result_peak !== mpk || int'(result_peak_pos) != mpos || result_delay !== 8'd7 || result_overlay !== 1'b0) begin failures++; $display("FAIL bp_result: got %0h@%0d d=%0d expected %0h@%0d d=7", result_peak, result_peak_pos, result_delay, mpk, mpos); end
      cd = int'(result_delay); co = int'(result_overlay); cpk = int'(result_peak); cpos = int'(result_peak_pos);
      for (int i = 1; i <= 50; i++) begin
        @(negedge clk);
        if (i <= 20) begin
          checks++; if (!result_valid || !busy || int'(result_delay) != cd || int'(result_overlay) != co || int'(result_peak) != cpk || int'(result_peak_pos) != cpos) begin failures++; $display("FAIL bp_stable@%0d: got v=%b d=%0d pk=%0h pos=%0d expected 1 %0d %0h %0d", i, result_valid, result_delay, result_peak, result_peak_pos, cd, cpk, cpos); end
        end else begin
          checks++; if (result_valid || busy || done || test_delay !== 8'd7 || test_rate !== 1'b1) begin failures++; $display("FAIL bp_abort@%0d: got v=%b busy=%b done=%b tdel=%0d expected 0 0 0 7", i, result_valid, busy, done, test_delay); end
        end
        if (i == 5) begin cfg_delay_first = 8'd100; start = 1'b1; end
        if (i == 6) start = 1'b0;
        if (i == 20) abort = 1'b1;
        if (i == 21) abort = 1'b0;
      end
    end
    result_ready = 1'b1;
  endtask
`else
  task automatic test_timeout();
    int s;
    result_ready = 1'b0;
    s = $urandom_range(0, 7);
    launch(1, 3, 1, 0, s, 0);
    collect(3000);
    checks++; if (coll_to != 0 || n_done != 1) begin failures++; $display("FAIL to_done: got done=%0d expected 1", n_done); end
    checks++; if (q_d.size() != 3 || q_vlen.size() != 3) begin failures++; $display("FAIL to_count: got %0d/%0d expected 3", q_d.size(), q_vlen.size()); end
    for (int j = 0; j < q_vlen.size() && j < 3; j++) begin
      checks++; if (q_vlen[j] != TO || q_d[j] != j + 1) begin failures++; $display("FAIL to_step[%0d]: got len %0d delay %0d expected %0d %0d", j, q_vlen[j], q_d[j], TO, j + 1); end
      checks++; if (q_rise[j] != c0 + 1 + S + D + j*(S + D + 2 + TO)) begin failures++; $display("FAIL to_timing[%0d]: got %0d expected %0d", j, q_rise[j] - c0, 1 + S + D + j*(S + D + 2 + TO)); end
    end
    checks++; if (result_dropped !== 1'b1) begin failures++; $display("FAIL to_dropped: got %b expected 1", result_dropped); end
    result_ready = 1'b1;
    launch(0, 0, 0, 0, 0, 0);
    checks++; if (result_dropped !== 1'b0) begin failures++; $display("FAIL to_clear: got %b expected 0", result_dropped); end
    collect(1000);
    checks++; if (result_dropped !== 1'b0 || q_d.size() != 1) begin failures++; $display("FAIL to_after: got dropped %b results %0d expected 0 1", result_dropped, q_d.size()); end
  endtask
`endif

  task automatic test_async_reset();
    result_ready = 1'b1;
    launch(50, 90, 20, 1, 2, 1);
    repeat (100) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({test_overlay, test_rate, test_delay, result_valid, result_delay, result_overlay,
         result_peak, result_peak_pos, busy, done, result_dropped} !== '0) begin
      failures++;
      $display("FAIL async_reset: got busy=%b tovl=%b tdel=%0d expected all 0", busy, test_overlay, test_delay);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; result_ready = 1'b1;
    cfg_delay_first = '0; cfg_delay_last = '0; cfg_delay_step = '0;
    cfg_overlay_mode = '0; cfg_rate = 1'b0; cfg_filter_sel = '0;
    filter_data = '0;
    test_reset();
    test_sweep();
    test_peak_tie();
    test_overlay_both();
    test_overflow();
    test_random_sweeps();
`ifndef FILTER_SCAN_SEQ_TIMEOUT_EN
    test_backpressure_abort();
`else
    test_timeout();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
